button_conditioner: RTL and testbench

- Conditions the raw game-control inputs on J39 (push buttons and switches) before they reach the game and TFT logic in top.
- Per input: 2-FF synchronizer, polarity normalization, counter debounce, and an edge/auto-repeat FSM.
- Emits clean levels plus single-cycle press, release and repeat pulses.
- Runs on the 12 MHz system clock.

---
 rtl/button_conditioner.sv | 171 +++++++++++++++++
 tb/tb_button_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and edge/auto-repeat detect raw button inputs
module button_conditioner #(
  parameter int NUM_BTN      = 8,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 120000,
  parameter int REPEAT_DELAY = 3600000,
  parameter int REPEAT_RATE  = 1200000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic [NUM_BTN-1:0] btn_event
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int DLY_W = $clog2(REPEAT_DELAY);
  localparam int RT_W  = $clog2(REPEAT_RATE);
  // One repeat counter serves both the initial delay and the repeat period.
  localparam int RP_W  = (DLY_W > RT_W) ? DLY_W : RT_W;

  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] DLY_MAX  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_MAX = RP_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [NUM_BTN-1:0] s1, s2, stable;
  logic [NUM_BTN-1:0] accept, rise, fall;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];

  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [RP_W-1:0]    rep_q   [NUM_BTN];
  logic [RP_W-1:0]    rep_d   [NUM_BTN];
  logic [NUM_BTN-1:0] press_d, release_d, repeat_d;

  // Two-flop synchronizer on polarity-normalized pins; reset value means "not pressed".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw ^ {NUM_BTN{ACTIVE_LOW}};
      s2 <= s1;
    end
  end

  // A new level is accepted on the cycle its persistence count completes.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      accept[i] = (s2[i] != stable[i]) && (db_cnt[i] == DB_MAX);
    end
  end

  assign rise = accept & s2;
  assign fall = accept & ~s2;

  // Debounce counter: any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Per-button edge/auto-repeat FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        rep_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        rep_q[i]   <= rep_d[i];
      end
    end
  end

  // Next-state and pulse decode; release outranks a coincident repeat.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      rep_d[i]   = rep_q[i];
      if (fall[i]) begin
        release_d[i] = 1'b1;
        state_d[i]   = IDLE;
        rep_d[i]     = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              press_d[i] = 1'b1;
              state_d[i] = HOLD;
              rep_d[i]   = '0;
            end
          end
          HOLD: begin
            if (rep_q[i] == DLY_MAX) begin
              // Saturate here while repeat is disabled; fire as soon as it is enabled.
              if (repeat_en[i]) begin
                repeat_d[i] = 1'b1;
                state_d[i]  = REPEAT;
                rep_d[i]    = '0;
              end
            end else begin
              rep_d[i] = rep_q[i] + RP_W'(1);
            end
          end
          REPEAT: begin
            if (!repeat_en[i]) begin
              // Park in HOLD already saturated so re-enabling repeats immediately.
              state_d[i] = HOLD;
              rep_d[i]   = DLY_MAX;
            end else if (rep_q[i] == RATE_MAX) begin
              repeat_d[i] = 1'b1;
              rep_d[i]    = '0;
            end else begin
              rep_d[i] = rep_q[i] + RP_W'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            rep_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Registered pulse outputs, aligned with the stable-level update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      btn_event   <= '0;
    end else begin
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_repeat  <= repeat_d;
      btn_event   <= press_d | repeat_d;
    end
  end

  assign btn_level = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_event;

  button_conditioner #(
    .NUM_BTN(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .btn_event(btn_event)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int kind;     // 0 press, 1 release, 2 repeat
    int b;
  } exp_t;

  typedef struct {
    int b;
    int hold;       // edges the raw pin is held pressed, starting at edge 1
    bit ren;
    bit exp_press;
    int exp_reps;
  } vec_t;

  exp_t         sbq[$];
  vec_t         vt[7];
  logic [N-1:0] exp_level = '0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_drained(string name);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never matched (got %0d pending, expected 0)",
               name, sbq.size(), sbq.size());
      sbq.delete();
    end
  endtask

  task automatic push(int e, int k, int b);
    exp_t x;
    x.edge_no = e;
    x.kind    = k;
    x.b       = b;
    sbq.push_back(x);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_level"},   btn_level,   '0);
    check({tag, "_press"},   btn_press,   '0);
    check({tag, "_release"}, btn_release, '0);
    check({tag, "_repeat"},  btn_repeat,  '0);
    check({tag, "_event"},   btn_event,   '0);
  endtask

  task automatic tick();
    logic [N-1:0] ep, er, et;
    @(posedge clk);
    cyc++;
    #1;
    ep = '0;
    er = '0;
    et = '0;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].edge_no == cyc) begin
        case (sbq[i].kind)
          0:       ep[sbq[i].b] = 1'b1;
          1:       er[sbq[i].b] = 1'b1;
          default: et[sbq[i].b] = 1'b1;
        endcase
        sbq.delete(i);
      end
    end
    exp_level = (exp_level | ep) & ~er;
    check("level",   btn_level,   exp_level);
    check("press",   btn_press,   ep);
    check("release", btn_release, er);
    check("repeat",  btn_repeat,  et);
    check("event",   btn_event,   ep | et);
  endtask

  task automatic run_to(int n);
    while (cyc < n) tick();
  endtask

  initial begin
    // {bit, hold edges, repeat_en, expect press, expected repeat count}
    vt[0] = '{0, 3,  1'b1, 1'b0, 0};  // glitch one cycle short of debounce
    vt[1] = '{0, 4,  1'b1, 1'b1, 0};  // shortest accepted press
    vt[2] = '{0, 20, 1'b1, 1'b1, 4};  // repeats at 16,19,22,25; release 26
    vt[3] = '{0, 19, 1'b1, 1'b1, 3};  // release at 25 swallows repeat at 25
    vt[4] = '{6, 10, 1'b1, 1'b1, 0};  // release at 16 swallows first repeat
    vt[5] = '{4, 30, 1'b0, 1'b1, 0};  // repeat disabled
    vt[6] = '{7, 11, 1'b1, 1'b1, 1};  // single repeat at 16, release 17

    // Reset asserted: everything low, then 50 idle cycles with pins released.
    #2;
    check_all_zero("in_reset");
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
    run_to(50);
    check_drained("idle_after_reset");

    // Table-driven single-button holds.
    for (int v = 0; v < 7; v++) begin
      cyc = 0;
      repeat_en = vt[v].ren ? '1 : '0;
      btn_raw[vt[v].b] = 1'b0;
      if (vt[v].exp_press) begin
        push(DB + 2, 0, vt[v].b);
        push(vt[v].hold + DB + 2, 1, vt[v].b);
        for (int k = 0; k < vt[v].exp_reps; k++) push(DB + 2 + RD + k * RR, 2, vt[v].b);
      end
      run_to(vt[v].hold);
      btn_raw[vt[v].b] = 1'b1;
      run_to(vt[v].hold + DB + 8);
      check_drained($sformatf("vec%0d", v));
    end

    // Bounce on bit 2: low 3, high 1, low 3, high; nothing may be accepted.
    cyc = 0;
    repeat_en = '1;
    btn_raw[2] = 1'b0;
    run_to(3);
    btn_raw[2] = 1'b1;
    run_to(4);
    btn_raw[2] = 1'b0;
    run_to(7);
    btn_raw[2] = 1'b1;
    run_to(20);
    check_drained("bounce");

    // Bit 3 held with repeat disabled, enabled late, dropped, re-enabled.
    cyc = 0;
    repeat_en = 8'hF7;
    btn_raw[3] = 1'b0;
    push(6, 0, 3);
    run_to(26);
    repeat_en[3] = 1'b1;
    push(27, 2, 3); push(30, 2, 3); push(33, 2, 3); push(36, 2, 3);
    run_to(37);
    repeat_en[3] = 1'b0;
    run_to(41);
    repeat_en[3] = 1'b1;
    push(42, 2, 3); push(45, 2, 3); push(48, 2, 3);
    run_to(45);
    btn_raw[3] = 1'b1;
    push(51, 1, 3);
    run_to(60);
    check_drained("late_enable");

    // Bits 1 and 5 together, reset pulsed mid-hold.
    cyc = 0;
    repeat_en = '0;
    btn_raw[1] = 1'b0;
    btn_raw[5] = 1'b0;
    push(6, 0, 1);
    push(6, 0, 5);
    run_to(12);
    #3;
    rst = 1'b0;
    #1;
    exp_level = '0;
    check_all_zero("async_reset");
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
    push(6, 0, 1);
    push(6, 0, 5);
    run_to(14);
    btn_raw[1] = 1'b1;
    btn_raw[5] = 1'b1;
    push(20, 1, 1);
    push(20, 1, 5);
    run_to(28);
    check_drained("reset_mid_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
